// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the
// IF/ID register. Handles stall/flush/redirect and a sticky fault for illegal fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;

  function automatic logic target_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= LAST_PC);
  endfunction

  assign pc_plus4_p0 = pc_p0 + 32'd4;
  assign imem_addr   = pc_p0;
  assign fault       = (state == FAULT);

  // PC register and IF/ID register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc_p0       <= RESET_PC;
      id_instr    <= 32'd0;
      id_pc_plus4 <= 32'd0;
      id_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            id_instr    <= 32'd0;
            id_pc_plus4 <= 32'd0;
            id_valid    <= 1'b0;
            if (target_legal(redirect_pc)) pc_p0 <= redirect_pc;
            else                           state <= FAULT;
          end else if (stall) begin
            if (flush) begin
              id_instr    <= 32'd0;
              id_pc_plus4 <= 32'd0;
              id_valid    <= 1'b0;
            end
          end else begin
            if (flush) begin
              id_instr    <= 32'd0;
              id_pc_plus4 <= 32'd0;
              id_valid    <= 1'b0;
            end else begin
              id_instr    <= imem_instr;
              id_pc_plus4 <= pc_plus4_p0;
              id_valid    <= 1'b1;
              fetch_count <= fetch_count + 32'd1;
            end
            // The last word ends the stream; the PC never wraps to 0
            if (pc_plus4_p0 <= LAST_PC) pc_p0 <= pc_plus4_p0;
            else                        state <= FAULT;
          end
        end
        FAULT: begin
          id_instr    <= 32'd0;
          id_pc_plus4 <= 32'd0;
          id_valid    <= 1'b0;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random control traffic,
// all compared against a behavioural reference model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned LAST      = MEM_BYTES - 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr, imem_instr = 32'd0;
  logic [31:0] id_instr, id_pc_plus4, fetch_count;
  logic        id_valid, fault;

  fetch_stage #(.RESET_PC(32'd0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_BYTES/4];

  // Instruction memory: samples the address on the falling edge
  always @(negedge clk) imem_instr = mem[imem_addr[9:2]];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_fault;

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bubble();
    m_instr = 32'd0;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
  endtask

  // One rising edge of the specified behaviour
  task automatic model_edge(input logic r, input logic s, input logic f,
                            input logic rd, input logic [31:0] rpc);
    if (r) begin
      m_pc = 32'd0; m_count = 32'd0; m_fault = 1'b0;
      bubble();
    end else if (m_fault) begin
      bubble();
    end else if (rd) begin
      bubble();
      if (rpc % 4 == 0 && rpc <= LAST) m_pc = rpc;
      else m_fault = 1'b1;
    end else if (s) begin
      if (f) bubble();
    end else begin
      if (f) bubble();
      else begin
        m_instr = mem[m_pc / 4];
        m_pc4   = m_pc + 4;
        m_valid = 1'b1;
        m_count = m_count + 1;
      end
      if (longint'(m_pc) + 4 <= LAST) m_pc = m_pc + 4;
      else m_fault = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("imem_addr",   imem_addr,   m_pc);
    chk("id_instr",    id_instr,    m_instr);
    chk("id_pc_plus4", id_pc_plus4, m_pc4);
    chk("id_valid",    {31'd0, id_valid}, {31'd0, m_valid});
    chk("fault",       {31'd0, fault},    {31'd0, m_fault});
    chk("fetch_count", fetch_count, m_count);
  endtask

  task automatic cycle(input logic r, input logic s, input logic f,
                       input logic rd, input logic [31:0] rpc);
    reset = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_edge(r, s, f, rd, rpc);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES/4; i++) mem[i] = $urandom;
    mem[0] = 32'h00000000; mem[1] = 32'h21080008;
    mem[2] = 32'h21290008; mem[3] = 32'h11090064;
    mem[32'h1A0/4] = 32'h01285020;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_count = 0; m_valid = 0; m_fault = 0;

    // Reset and four free-running fetches
    cycle(1, 0, 0, 0, 0);
    chk("reset_valid", {31'd0, id_valid}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    chk("run4_instr", id_instr, 32'h11090064);
    chk("run4_pc4", id_pc_plus4, 32'd16);
    chk("run4_count", fetch_count, 32'd4);

    // Stall for three cycles at pc=8
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk("stall_addr", imem_addr, 32'd8);
      chk("stall_instr", id_instr, 32'h21080008);
      chk("stall_count", fetch_count, 32'd2);
    end
    cycle(0, 0, 0, 0, 0);
    chk("release_instr", id_instr, 32'h21290008);
    chk("release_pc4", id_pc_plus4, 32'd12);
    cycle(0, 0, 0, 0, 0);

    // Redirect to 0x1A0 from pc=16
    chk("pre_redirect_pc", imem_addr, 32'd16);
    cycle(0, 0, 0, 1, 32'h1A0);
    chk("redirect_bubble", {31'd0, id_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("redirect_instr", id_instr, 32'h01285020);
    chk("redirect_pc4", id_pc_plus4, 32'h1A4);

    // Redirect wins over stall and flush
    cycle(0, 1, 1, 1, 32'h40);
    chk("rsf_addr", imem_addr, 32'h40);
    cycle(0, 0, 0, 0, 0);
    chk("rsf_instr", id_instr, mem[32'h40/4]);

    // Flush during stall, then flush during advance
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Illegal redirect targets fault until reset
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0, 1, (k == 0) ? 32'h1A2 : 32'h400);
      chk("bad_fault", {31'd0, fault}, 32'd1);
      for (int i = 0; i < 4; i++) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1),
                                        $urandom_range(0, 1), 32'h10);
      cycle(1, 0, 0, 0, 0);
      chk("bad_reset_addr", imem_addr, 32'd0);
    end

    // Run off the end of memory
    cycle(0, 0, 0, 1, 32'd1008);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    chk("end_instr", id_instr, mem[255]);
    chk("end_valid", {31'd0, id_valid}, 32'd1);
    chk("end_fault", {31'd0, fault}, 32'd1);
    cycle(0, 0, 0, 0, 0);
    chk("end_hold_addr", imem_addr, 32'd1020);

    // Random control traffic
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047)
                                         : ($urandom_range(0, 255) * 4);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, tgt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter, drives the byte address into the instruction memory, and captures the returned word into the IF/ID pipeline register with its PC+4. It supports the following:
- stall, flush and branch/jump redirect from later stages;
- a fetch counter;
- a sticky fault state for illegal fetch addresses.

It sits directly upstream of the instruction memory. It is also the producer of the IF/ID register consumed by decode.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded by reset (word-aligned).
- MEM_BYTES, 1024, instruction-memory size in bytes; legal fetch addresses are 0..MEM_BYTES-4.

Ports:
- clk  in  1  single clock; all state updates on rising edge. Instruction memory samples `imem_addr` on the falling edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  replace IF/ID contents with a bubble.
- redirect  in  1  load `redirect_pc` into PC (taken branch/jump).
- redirect_pc  in  32  byte target address.
- imem_addr  out  32  byte address to instruction memory; combinational copy of PC.
- imem_instr  in  32  word returned by instruction memory (valid after falling edge of the same cycle).
- id_instr  out  32  IF/ID instruction.
- id_pc_plus4  out  32  IF/ID PC+4 of that instruction.
- id_valid  out  1  IF/ID holds a real instruction.
- fault  out  1  sticky illegal-fetch flag.
- fetch_count  out  32  number of instructions delivered to IF/ID since reset.

## Operation
- States are RUN and FAULT; reset enters RUN.
- Reset values:
  - pc=RESET_PC;
  - id_instr=0 (NOP);
  - id_pc_plus4=0;
  - id_valid=0;
  - fault=0;
  - fetch_count=0.
- RUN, priority per rising edge is reset > redirect > stall > normal advance:
  - redirect, target legal (redirect_pc[1:0]==0 and redirect_pc<=MEM_BYTES-4):
    - pc<=redirect_pc;
    - IF/ID<=bubble (id_instr=0, id_pc_plus4=0, id_valid=0);
    - stall ignored.
  - redirect, target illegal:
    - go to FAULT;
    - pc unchanged;
    - IF/ID<=bubble.
  - stall, no redirect:
    - pc held;
    - IF/ID held, unless flush is also high, in which case IF/ID<=bubble.
  - normal advance:
    - id_instr<=imem_instr;
    - id_pc_plus4<=pc+4;
    - id_valid<=1;
    - fetch_count++.
    - If flush is high, IF/ID<=bubble instead and fetch_count is not incremented.
    - pc<=pc+4 if pc+4<=MEM_BYTES-4.
    - Otherwise (pc==MEM_BYTES-4) the last word is still latched (normal or flushed), pc is held, and the state goes to FAULT. There is no wrap to 0.
- FAULT:
  - fault=1;
  - IF/ID forced to bubble;
  - pc frozen;
  - fetch_count frozen;
  - stall/flush/redirect ignored.
  - Only reset exits.
- Arithmetic:
  - pc+4 is 32-bit unsigned.
  - Comparisons against MEM_BYTES-4 are unsigned.
  - fetch_count wraps modulo 2^32.

## Timing
- imem_addr equals pc combinationally throughout the cycle. Memory returns the word by the falling edge.
- The next rising edge latches it into IF/ID, giving 1-cycle latency from PC=P to id_instr=mem[P].
- Sustained throughput is one instruction per cycle.
- The first valid IF/ID word appears on the second rising edge after reset deasserts. The first edge is the reset edge.
- Redirect costs one bubble: the edge that loads the target produces id_valid=0, and the following edge delivers mem[target].
- Stall may be held for any number of cycles. Memory re-reads the same address, and IF/ID contents stay bit-identical.
- Reset asserted mid-stream, on any edge and in any state, overrides everything and restores reset values that edge.

## Test plan
- Reset, then 4 free-running cycles with mem[0..15] = 0x00000000, 0x21080008, 0x21290008, 0x11090064:
  - id_instr follows that sequence;
  - id_pc_plus4 = 4, 8, 12, 16;
  - id_valid=1 from the 2nd edge;
  - fetch_count=4.
- Stall held 3 cycles while pc=8:
  - imem_addr stays 8;
  - id_instr stays 0x21080008;
  - fetch_count unchanged.
  - After release, 0x21290008 arrives with id_pc_plus4=12.
- Redirect to 0x1A0 while pc=16:
  - next edge gives id_valid=0 and id_instr=0;
  - following edge gives id_instr=0x01285020 with id_pc_plus4=0x1A4.
- Redirect asserted together with stall and flush: redirect wins, pc<=target, and one bubble is produced.
- Redirect to 0x1A2 (misaligned), and separately to 0x400:
  - fault=1;
  - id_valid=0 forever;
  - pc is unchanged;
  - reset clears fault and pc returns to 0.
- Free-run to pc=1020:
  - mem[1020] is delivered valid;
  - next state is FAULT with imem_addr=1020 held;
  - no fetch from address 0 occurs.
